// File: rtl/decompress_controller.sv
// VQ decoder controller: loads the codebook from RAM_W, then streams tags from
// RAM_TAG and writes the selected codewords to RAM_RI. It runs once per reset.
module decompress_controller #(
  parameter int N_CODE = 64,
  parameter int N_VEC  = 4096,
  parameter int DW     = 24,
  parameter int AW     = 18
) (
  input  logic          clk,
  input  logic          rst,
  output logic          RAM_W_OE,
  output logic [AW-1:0] RAM_W_A,
  input  logic [DW-1:0] RAM_W_Q,
  output logic          RAM_TAG_OE,
  output logic [AW-1:0] RAM_TAG_A,
  input  logic [DW-1:0] RAM_TAG_Q,
  output logic          RAM_RI_WE,
  output logic [AW-1:0] RAM_RI_A,
  output logic [DW-1:0] RAM_RI_D,
  output logic          done
);
  localparam int TW = $clog2(N_CODE);

  typedef enum logic [2:0] {INIT, LOAD_CB, DECODE, DRAIN, FINISH} state_t;

  state_t          state_q;
  logic            drain_q;
  logic            w_oe_q, tag_oe_q, ri_we_q, done_q;
  logic [AW-1:0]   w_a_q, tag_a_q, ri_a_q;
  logic [DW-1:0]   ri_d_q;

  logic            cbv_q;
  logic [TW-1:0]   cb_addr_q;
  logic            tagv_q;
  logic [AW-1:0]   tag_addr_q;

  logic [DW-1:0]   cb_q [N_CODE];
  logic [DW-1:0]   codeword;
  logic            unused_tag_bits;

  assign codeword        = cb_q[RAM_TAG_Q[TW-1:0]];
  assign unused_tag_bits = ^RAM_TAG_Q[DW-1:TW];

  // Codebook storage carries no reset; the reset valid flag gates every write.
  always_ff @(posedge clk) begin
    if (cbv_q) cb_q[cb_addr_q] <= RAM_W_Q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      drain_q    <= 1'b0;
      w_oe_q     <= 1'b0;
      w_a_q      <= '0;
      tag_oe_q   <= 1'b0;
      tag_a_q    <= '0;
      ri_we_q    <= 1'b0;
      ri_a_q     <= '0;
      ri_d_q     <= '0;
      done_q     <= 1'b0;
      cbv_q      <= 1'b0;
      cb_addr_q  <= '0;
      tagv_q     <= 1'b0;
      tag_addr_q <= '0;
    end else begin
      // Read data arrives one cycle after the address; these flags track it.
      cbv_q      <= w_oe_q;
      cb_addr_q  <= w_a_q[TW-1:0];
      tagv_q     <= tag_oe_q;
      tag_addr_q <= tag_a_q;
      ri_we_q    <= tagv_q;
      if (tagv_q) begin
        ri_a_q <= tag_addr_q;
        ri_d_q <= codeword;
      end

      case (state_q)
        INIT: begin
          state_q <= LOAD_CB;
          w_oe_q  <= 1'b1;
          w_a_q   <= '0;
        end
        LOAD_CB: begin
          if (w_a_q == AW'(N_CODE - 1)) begin
            state_q  <= DECODE;
            w_oe_q   <= 1'b0;
            tag_oe_q <= 1'b1;
            tag_a_q  <= '0;
          end else begin
            w_a_q <= w_a_q + AW'(1);
          end
        end
        DECODE: begin
          if (tag_a_q == AW'(N_VEC - 1)) begin
            state_q  <= DRAIN;
            tag_oe_q <= 1'b0;
            drain_q  <= 1'b0;
          end else begin
            tag_a_q <= tag_a_q + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        FINISH: ;
        default: state_q <= INIT;
      endcase
    end
  end

  assign RAM_W_OE   = w_oe_q;
  assign RAM_W_A    = w_a_q;
  assign RAM_TAG_OE = tag_oe_q;
  assign RAM_TAG_A  = tag_a_q;
  assign RAM_RI_WE  = ri_we_q;
  assign RAM_RI_A   = ri_a_q;
  assign RAM_RI_D   = ri_d_q;
  assign done       = done_q;
endmodule

// File: tb/tb_decompress_controller.sv
// Scoreboarded bench for decompress_controller: RAM models, a codebook/tag
// reference image pushed per run, and a cycle-timed monitor.
module tb_decompress_controller;
  localparam int AW = 18;
  localparam int DW = 24;
  localparam int NC = 64;
  localparam int NV = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RAM_W_OE, RAM_TAG_OE, RAM_RI_WE, done;
  logic [AW-1:0] RAM_W_A, RAM_TAG_A, RAM_RI_A;
  logic [DW-1:0] RAM_W_Q, RAM_TAG_Q, RAM_RI_D;

  always #5 clk = ~clk;

  decompress_controller #(.N_CODE(NC), .N_VEC(NV), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .RAM_W_OE(RAM_W_OE), .RAM_W_A(RAM_W_A), .RAM_W_Q(RAM_W_Q),
    .RAM_TAG_OE(RAM_TAG_OE), .RAM_TAG_A(RAM_TAG_A), .RAM_TAG_Q(RAM_TAG_Q),
    .RAM_RI_WE(RAM_RI_WE), .RAM_RI_A(RAM_RI_A), .RAM_RI_D(RAM_RI_D),
    .done(done)
  );

  logic [DW-1:0] wmem [NC];
  logic [DW-1:0] tmem [NV];

  always @(posedge clk) begin
    if (RAM_W_OE)   RAM_W_Q   <= wmem[RAM_W_A[5:0]];
    if (RAM_TAG_OE) RAM_TAG_Q <= tmem[RAM_TAG_A[11:0]];
  end

  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
    end
  endtask

  logic [AW-1:0] snap_wa, snap_ta, snap_ra;
  logic [DW-1:0] snap_rd;

  // Monitor: expected timing is written directly from the edge count since reset release.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      int e;
      e = edge_n;
      if (e == 0) begin
        check("rst_w_a", 32'(RAM_W_A), 32'd0);
        check("rst_tag_a", 32'(RAM_TAG_A), 32'd0);
        check("rst_ri_a", 32'(RAM_RI_A), 32'd0);
        check("rst_ri_d", 32'(RAM_RI_D), 32'd0);
      end
      check("w_oe", 32'(RAM_W_OE), 32'(e >= 1 && e <= 64));
      if (e >= 1 && e <= 64) check("w_a", 32'(RAM_W_A), 32'(e - 1));
      check("tag_oe", 32'(RAM_TAG_OE), 32'(e >= 65 && e <= 4160));
      if (e >= 65 && e <= 4160) check("tag_a", 32'(RAM_TAG_A), 32'(e - 65));
      check("ri_we", 32'(RAM_RI_WE), 32'(e >= 67 && e <= 4162));
      if (RAM_RI_WE) begin
        if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          wr_t x;
          x = q.pop_front();
          check("ri_a", 32'(RAM_RI_A), 32'(x.a));
          check("ri_d", 32'(RAM_RI_D), 32'(x.d));
        end
      end
      check("done", 32'(done), 32'(e >= 4163));
      if (e == 4163) begin
        snap_wa = RAM_W_A; snap_ta = RAM_TAG_A; snap_ra = RAM_RI_A; snap_rd = RAM_RI_D;
      end else if (e > 4163) begin
        check("hold_w_a", 32'(RAM_W_A), 32'(snap_wa));
        check("hold_tag_a", 32'(RAM_TAG_A), 32'(snap_ta));
        check("hold_ri_a", 32'(RAM_RI_A), 32'(snap_ra));
        check("hold_ri_d", 32'(RAM_RI_D), 32'(snap_rd));
      end
    end
  end

  // Reference image: write n carries the codeword named by tag n's low six bits.
  task automatic push_expected();
    q.delete();
    for (int n = 0; n < NV; n++) begin
      wr_t x;
      x.a = AW'(n);
      x.d = wmem[tmem[n][5:0]];
      q.push_back(x);
    end
  endtask

  task automatic fill(input int scen);
    for (int k = 0; k < NC; k++)
      wmem[k] = (scen == 0) ? DW'(k * 32'h010101) : DW'($urandom);
    for (int n = 0; n < NV; n++) begin
      case (scen)
        0:       tmem[n] = DW'(n % 64);
        1:       tmem[n] = {18'($urandom_range(1, 262143)), 6'd63};
        default: tmem[n] = DW'($urandom);
      endcase
    end
    if (scen == 2) begin
      wmem[63] = 24'hABCDEF;
      tmem[0]  = {18'($urandom), 6'd63};
    end
  endtask

  task automatic run(input int scen, input bit mid_reset, input int hold);
    int cyc;
    @(posedge clk); #2 rst = 1'b1;
    fill(scen);
    repeat (2) @(posedge clk);
    push_expected();
    #2 rst = 1'b0;
    if (mid_reset) begin
      cyc = 0;
      while (edge_n < 2000 && cyc < 2100) begin @(posedge clk); cyc++; end
      check("mid_reach", 32'(edge_n >= 2000), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_w_oe", 32'(RAM_W_OE), 32'd0);
      check("mid_tag_oe", 32'(RAM_TAG_OE), 32'd0);
      check("mid_ri_we", 32'(RAM_RI_WE), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_w_a", 32'(RAM_W_A), 32'd0);
      check("mid_tag_a", 32'(RAM_TAG_A), 32'd0);
      check("mid_ri_a", 32'(RAM_RI_A), 32'd0);
      check("mid_ri_d", 32'(RAM_RI_D), 32'd0);
      repeat (3) @(posedge clk);
      push_expected();
      #2 rst = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin @(posedge clk); cyc++; end
    check("done_timeout", 32'(done), 32'd1);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    chk_en = 1'b1;
    run(0, 1'b0, 3);
    run(1, 1'b0, 3);
    run(2, 1'b0, 3);
    run(3, 1'b1, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
